// File: rtl/checkbits_tx.sv
// Checkpoint-code transmitter: Wishbone-fed FIFO that presents each 16-bit code on checkbits
// for a minimum hold time. Optional START->END cycle counter enabled by CHECKBITS_CYCLE_CNT_EN.
module checkbits_tx #(
    parameter int          DEPTH       = 4,
    parameter int          HOLD_CYCLES = 8,
    parameter logic [15:0] START_CODE  = 16'hAB40,
    parameter logic [15:0] END_CODE    = 16'hAB51
) (
    input  logic        clock,
    input  logic        RSTB,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic [15:0] checkbits,
    output logic [15:0] checkbits_oeb,
    output logic        busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);
    localparam logic [4:0]    FULL_CNT  = 5'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    state_t        state;
    logic [HW-1:0] hold_cnt;
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [4:0]    fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          access;
    logic          code_wr;
    logic          pop;
    logic          push;
    logic          ack_go;
    logic [15:0]   head;
    logic          running;
    logic [31:0]   cycle_cnt;
    logic [31:0]   rdata;
    logic          unused_dat;

    assign unused_dat = ^wb_dat_i[31:16];

    assign fifo_empty = (fifo_count == 5'd0);
    assign fifo_full  = (fifo_count == FULL_CNT);
    assign access     = wb_cyc_i & wb_stb_i;
    assign code_wr    = wb_we_i & (wb_adr_i == 4'h0);
    assign pop        = (state == LOAD);
    // A full FIFO can still take a write in the cycle the FSM pops the head.
    assign ack_go     = access & ~wb_ack_o & (~code_wr | ~fifo_full | pop);
    assign push       = ack_go & code_wr;
    assign head       = mem[rd_ptr];
    assign busy       = (state != IDLE) | ~fifo_empty;

    always_comb begin
        rdata = '0;
        case (wb_adr_i)
            4'h4:    rdata = {16'b0, 3'b0, fifo_count, 5'b0, running, fifo_full, fifo_empty};
            4'h8:    rdata = cycle_cnt;
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clock or negedge RSTB) begin
        if (!RSTB) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= ack_go;
            wb_dat_o <= (ack_go & ~wb_we_i) ? rdata : 32'h0;
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= wb_dat_i[15:0];
    end

    always_ff @(posedge clock or negedge RSTB) begin
        if (!RSTB) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= fifo_count + {4'b0, push} - {4'b0, pop};
        end
    end

    // Once the first code is loaded the pads stay driven; IDLE keeps showing the last code.
    always_ff @(posedge clock or negedge RSTB) begin
        if (!RSTB) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            checkbits     <= '0;
            checkbits_oeb <= 16'hFFFF;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty)
                        state <= LOAD;
                end
                LOAD: begin
                    checkbits     <= head;
                    checkbits_oeb <= '0;
                    hold_cnt      <= HOLD_INIT;
                    state         <= HOLD;
                end
                HOLD: begin
                    if (hold_cnt == '0)
                        state <= fifo_empty ? IDLE : LOAD;
                    else
                        hold_cnt <= hold_cnt - HW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CHECKBITS_CYCLE_CNT_EN
    // The count includes the edge on which END_CODE appears, so it equals the edge distance.
    always_ff @(posedge clock or negedge RSTB) begin
        if (!RSTB) begin
            cycle_cnt <= '0;
            running   <= 1'b0;
        end else if (pop && head == START_CODE) begin
            cycle_cnt <= '0;
            running   <= 1'b1;
        end else begin
            if (running && cycle_cnt != 32'hFFFF_FFFF)
                cycle_cnt <= cycle_cnt + 32'd1;
            if (pop && head == END_CODE)
                running <= 1'b0;
        end
    end
`else
    logic unused_codes;
    assign unused_codes = ^{START_CODE, END_CODE};
    assign cycle_cnt    = '0;
    assign running      = 1'b0;
`endif

endmodule

// File: tb/tb_checkbits_tx.sv
// Self-checking bench for checkbits_tx: register table, scoreboard of displayed codes,
// hold/latency/stall sequences, cycle counter and mid-operation reset.
module tb_checkbits_tx;

    localparam int HOLD  = 8;
    localparam int DEPTH = 4;

    logic        clock;
    logic        RSTB;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic        wb_ack_o;
    logic [31:0] wb_dat_o;
    logic [15:0] checkbits;
    logic [15:0] checkbits_oeb;
    logic        busy;

    checkbits_tx #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .clock(clock), .RSTB(RSTB),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o),
        .checkbits(checkbits), .checkbits_oeb(checkbits_oeb), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc_n = 0;
    always @(posedge clock) cyc_n <= cyc_n + 1;

    int tests = 0;
    int fails = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_cb;
    int run_len;
    bit run_valid;

    typedef struct {
        logic [3:0]  adr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] expd;
        string       name;
    } vec_t;
    vec_t vecs[9];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expd);
        tests++;
        if (act !== expd) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, expd);
        end
    endtask

    task automatic flag_fail(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: got timeout/unexpected, expected event", name);
    endtask

    // Every change of checkbits must match the next queued code and end a long-enough hold.
    always @(negedge clock) begin
        if (!RSTB) begin
            last_cb   = 16'h0;
            run_len   = 0;
            run_valid = 0;
        end else if (checkbits !== last_cb) begin
            if (run_valid)
                check_output("hold_length_ok", 32'(run_len >= HOLD), 32'd1);
            if (exp_q.size() == 0)
                flag_fail("unexpected_code");
            else
                check_output("scoreboard_code", {16'h0, checkbits}, {16'h0, exp_q.pop_front()});
            last_cb   = checkbits;
            run_len   = 1;
            run_valid = 1;
        end else if (run_valid) begin
            run_len++;
        end
    end

    task automatic wb_write(input logic [3:0] adr, input logic [31:0] dat, output int ack_cyc);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = adr; wb_dat_i = dat;
        ack_cyc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (wb_ack_o) begin
                ack_cyc = cyc_n;
                break;
            end
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        if (ack_cyc < 0) flag_fail("wb_write_ack");
    endtask

    task automatic wb_read(input logic [3:0] adr, output logic [31:0] data);
        bit got = 0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = adr;
        data = 32'hDEAD_BEEF;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (wb_ack_o) begin
                data = wb_dat_o;
                got = 1;
                break;
            end
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        if (!got) flag_fail("wb_read_ack");
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (!busy) begin
                done = 1;
                break;
            end
        end
        if (!done) flag_fail("wait_idle");
    endtask

    task automatic apply_stimulus(input vec_t v);
        logic [31:0] rd;
        int a;
        if (v.we) begin
            wb_write(v.adr, v.wdata, a);
            check_output(v.name, {31'b0, busy}, v.expd);
        end else begin
            wb_read(v.adr, rd);
            check_output(v.name, rd, v.expd);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_checkbits"}, {16'h0, checkbits}, 32'h0);
        check_output({tag, "_oeb"}, {16'h0, checkbits_oeb}, 32'h0000_FFFF);
        check_output({tag, "_busy"}, {31'b0, busy}, 32'h0);
        check_output({tag, "_ack"}, {31'b0, wb_ack_o}, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] exp_cycles;
        logic [31:0] exp_run;
        int a, a1, a2, b2, b3, n;
        int acks[6];
        logic [15:0] burst[6];

`ifdef CHECKBITS_CYCLE_CNT_EN
        exp_run = 32'h0000_0005;
`else
        exp_run = 32'h0000_0001;
`endif

        vecs[0] = '{4'h0, 1'b0, 32'h0,         32'h0,         "read_code_reg"};
        vecs[1] = '{4'h4, 1'b0, 32'h0,         32'h0000_0001, "status_reset"};
        vecs[2] = '{4'h8, 1'b0, 32'h0,         32'h0,         "cycles_reset"};
        vecs[3] = '{4'hC, 1'b0, 32'h0,         32'h0,         "unmapped_read"};
        vecs[4] = '{4'h4, 1'b1, 32'hFFFF_FFFF, 32'h0,         "write_status_ignored"};
        vecs[5] = '{4'h8, 1'b1, 32'h0000_1234, 32'h0,         "write_cycles_ignored"};
        vecs[6] = '{4'hC, 1'b1, 32'h0000_5555, 32'h0,         "write_unmapped_ignored"};
        vecs[7] = '{4'h4, 1'b0, 32'h0,         32'h0000_0001, "status_after_writes"};
        vecs[8] = '{4'h8, 1'b0, 32'h0,         32'h0,         "cycles_after_writes"};

        RSTB = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_adr_i = 4'h0; wb_dat_i = 32'h0;
        #2000;
        check_reset_outputs("reset");
        @(posedge clock); #2 RSTB = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 9; i++) apply_stimulus(vecs[i]);

        // END without START leaves the counter alone
        exp_q.push_back(16'hAB51);
        wb_write(4'h0, 32'h0000_AB51, a);
        wait_idle();
        wb_read(4'h8, rd); check_output("end_only_cycles", rd, 32'h0);
        wb_read(4'h4, rd); check_output("end_only_status", rd, 32'h0000_0001);

        // Back-to-back burst: the sixth write must stall until the FSM pops again
        burst = '{16'h003E, 16'h0044, 16'h004A, 16'h0050, 16'hAB51, 16'h0056};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(burst[i]);
            wb_write(4'h0, {16'h0, burst[i]}, acks[i]);
        end
        check_output("full_stall_ack", 32'(acks[5] - acks[0]), 32'(HOLD + 3));
        wb_read(4'h4, rd); check_output("status_full", rd, 32'h0000_0402);
        wait_idle();
        check_output("burst_all_seen", 32'(exp_q.size()), 32'h0);

        // Single write when idle: 2-cycle latency, exact hold, code persists
        exp_q.push_back(16'h003E);
        wb_write(4'h0, 32'h0000_003E, a);
        @(negedge clock); check_output("latency_not_early", {16'h0, checkbits}, 32'h0000_0056);
        @(negedge clock); check_output("latency_2", {16'h0, checkbits}, 32'h0000_003E);
        n = 0;
        while (busy && n < 50) begin
            n++;
            @(negedge clock);
        end
        check_output("hold_exact", 32'(n), 32'(HOLD));
        repeat (5) @(negedge clock);
        check_output("code_persists", {16'h0, checkbits}, 32'h0000_003E);
        check_output("oeb_driven", {16'h0, checkbits_oeb}, 32'h0);

        // Identical codes are not merged: two full hold slots plus the second LOAD
        exp_q.push_back(16'h0055);
        wb_write(4'h0, 32'h0000_0055, a);
        wb_write(4'h0, 32'h0000_0055, a);
        n = 0;
        while (busy && n < 100) begin
            if (checkbits == 16'h0055) n++;
            @(negedge clock);
        end
        check_output("repeat_no_merge", 32'(n), 32'(2 * HOLD + 1));

        // START, idle, END: count equals distance between the two appearances
        exp_q.push_back(16'hAB40);
        wb_write(4'h0, 32'h0000_AB40, a1);
        repeat (100) @(negedge clock);
        wb_read(4'h4, rd); check_output("status_running", rd, exp_run);
        exp_q.push_back(16'hAB51);
        wb_write(4'h0, 32'h0000_AB51, a2);
`ifdef CHECKBITS_CYCLE_CNT_EN
        exp_cycles = 32'(a2 - a1);
`else
        exp_cycles = 32'h0;
`endif
        wait_idle();
        wb_read(4'h8, rd); check_output("cycles_start_end", rd, exp_cycles);
        wb_read(4'h4, rd); check_output("status_stopped", rd, 32'h0000_0001);
        repeat (10) @(negedge clock);
        wb_read(4'h8, rd); check_output("cycles_frozen", rd, exp_cycles);

        // START twice restarts the count from the second one
        exp_q.push_back(16'hAB40);
        wb_write(4'h0, 32'h0000_AB40, a);
        repeat (20) @(negedge clock);
        wb_write(4'h0, 32'h0000_AB40, b2);
        repeat (30) @(negedge clock);
        exp_q.push_back(16'hAB51);
        wb_write(4'h0, 32'h0000_AB51, b3);
        wait_idle();
`ifdef CHECKBITS_CYCLE_CNT_EN
        exp_cycles = 32'(b3 - b2);
`else
        exp_cycles = 32'h0;
`endif
        wb_read(4'h8, rd); check_output("cycles_restart", rd, exp_cycles);

        // Reset during HOLD with three codes queued
        exp_q.push_back(16'h0101);
        wb_write(4'h0, 32'h0000_0101, a);
        wb_write(4'h0, 32'h0000_0202, a);
        wb_write(4'h0, 32'h0000_0303, a);
        wb_write(4'h0, 32'h0000_0404, a);
        @(posedge clock); #2 RSTB = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clock);
        check_reset_outputs("midreset");
        @(posedge clock); #2 RSTB = 1'b1;
        @(negedge clock);
        wb_read(4'h4, rd); check_output("status_after_midreset", rd, 32'h0000_0001);
        wb_read(4'h8, rd); check_output("cycles_after_midreset", rd, 32'h0);
        exp_q.push_back(16'h1234);
        wb_write(4'h0, 32'h0000_1234, a);
        @(negedge clock); check_output("post_reset_not_early", {16'h0, checkbits}, 32'h0);
        @(negedge clock); check_output("post_reset_latency", {16'h0, checkbits}, 32'h0000_1234);
        wait_idle();
        repeat (5) @(negedge clock);
        check_output("no_stale_code", {16'h0, checkbits}, 32'h0000_1234);
        check_output("final_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
